// File: rtl/fp_cvt_unit.sv
// Single-precision <-> 32-bit integer converter (FCVT.S.W/WU, FCVT.W/WU.S).
// Iterative: INT->FP normalises one bit per cycle, FP->INT aligns one bit per cycle.
module fp_cvt_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cvt_valid,
   output logic        cvt_ready,
   input  logic        cvt_dir,
   input  logic        cvt_signed,
   input  logic [31:0] src,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res,
   output logic [4:0]  fflags
);

   typedef enum logic [2:0] {IDLE, NORM, ROUND, SHIFT, DONE} state_t;

   localparam logic [4:0] FLAG_NV = 5'b10000;

   state_t      state_q;
   logic [31:0] mag_q;
   logic [4:0]  lz_q;
   logic [4:0]  cnt_q;
   logic        neg_q;
   logic        sticky_q;
   logic [31:0] res_q;
   logic [4:0]  flags_q;
   logic        valid_q;

   logic [7:0]  src_e;
   logic        src_nan;
   logic        int_neg;
   logic [31:0] int_mag;
   logic [4:0]  shr_cnt_d;
   logic        fp_special;
   logic [31:0] sp_res;
   logic [4:0]  sp_flags;
   logic        rnd_guard;
   logic        rnd_sticky;
   logic        rnd_inc;
   logic [7:0]  rnd_exp;
   logic [30:0] rounded;
   logic [31:0] shift_res;

   always_comb begin
      src_e     = src[30:23];
      src_nan   = (src_e == 8'hFF) && (src[22:0] != 23'd0);
      int_neg   = cvt_signed && src[31];
      int_mag   = int_neg ? (~src + 32'd1) : src;
      shr_cnt_d = 5'(8'd158 - src_e);

      // Everything that resolves in the accept cycle without alignment.
      fp_special = 1'b1;
      sp_res     = '0;
      sp_flags   = '0;
      if (src_nan) begin
         sp_res   = cvt_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
         sp_flags = FLAG_NV;
      end else if (src_e < 8'd127) begin
         sp_flags = {4'b0000, src[30:0] != 31'd0};
      end else if (cvt_signed) begin
         if (src_e >= 8'd158 && src != 32'hCF00_0000) begin
            sp_res   = src[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            sp_flags = FLAG_NV;
         end else begin
            fp_special = 1'b0;
         end
      end else if (src[31]) begin
         sp_flags = FLAG_NV;
      end else if (src_e >= 8'd159) begin
         sp_res   = 32'hFFFF_FFFF;
         sp_flags = FLAG_NV;
      end else begin
         fp_special = 1'b0;
      end

      // Adding the increment across {exp,mant} carries mantissa overflow into exp.
      rnd_guard  = mag_q[7];
      rnd_sticky = mag_q[6:0] != 7'd0;
      rnd_inc    = rnd_guard && (rnd_sticky || mag_q[8]);
      rnd_exp    = 8'd158 - {3'b000, lz_q};
      rounded    = {rnd_exp, mag_q[30:8]} + {30'd0, rnd_inc};

      shift_res  = neg_q ? (~mag_q + 32'd1) : mag_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mag_q    <= '0;
         lz_q     <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         sticky_q <= 1'b0;
         res_q    <= '0;
         flags_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cvt_valid) begin
                  lz_q     <= '0;
                  sticky_q <= 1'b0;
                  if (!cvt_dir) begin
                     neg_q <= int_neg;
                     mag_q <= int_mag;
                     if (int_mag == 32'd0) begin
                        res_q   <= '0;
                        flags_q <= '0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        state_q <= NORM;
                     end
                  end else begin
                     neg_q <= src[31];
                     mag_q <= {1'b1, src[22:0], 8'h00};
                     cnt_q <= shr_cnt_d;
                     if (fp_special) begin
                        res_q   <= sp_res;
                        flags_q <= sp_flags;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        state_q <= SHIFT;
                     end
                  end
               end
            end
            NORM: begin
               if (mag_q[31]) begin
                  state_q <= ROUND;
               end else begin
                  mag_q <= {mag_q[30:0], 1'b0};
                  lz_q  <= lz_q + 5'd1;
               end
            end
            ROUND: begin
               res_q   <= {neg_q, rounded};
               flags_q <= {4'b0000, rnd_guard || rnd_sticky};
               valid_q <= 1'b1;
               state_q <= DONE;
            end
            SHIFT: begin
               if (cnt_q != 5'd0) begin
                  mag_q    <= {1'b0, mag_q[31:1]};
                  sticky_q <= sticky_q || mag_q[0];
                  cnt_q    <= cnt_q - 5'd1;
               end else begin
                  res_q   <= shift_res;
                  flags_q <= {4'b0000, sticky_q};
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_q   <= '0;
                  flags_q <= '0;
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cvt_ready = (state_q == IDLE);
   assign res_valid = valid_q;
   assign res       = res_q;
   assign fflags    = flags_q;

endmodule

// File: tb/tb_fp_cvt_unit.sv
// Directed-vector bench for fp_cvt_unit: results, flags and latency against
// hand-computed values, plus backpressure and mid-conversion reset.
module tb_fp_cvt_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cvt_valid = 1'b0;
   logic        cvt_ready;
   logic        cvt_dir = 1'b0;
   logic        cvt_signed = 1'b0;
   logic [31:0] src = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res;
   logic [4:0]  fflags;

   int n_checks = 0;
   int n_errors = 0;

   fp_cvt_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cvt_valid  (cvt_valid),
      .cvt_ready  (cvt_ready),
      .cvt_dir    (cvt_dir),
      .cvt_signed (cvt_signed),
      .src        (src),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res        (res),
      .fflags     (fflags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp_v);
      end
   endtask

   // Issue one request, wait (bounded) for the result, check it, then consume it.
   task automatic run(input string tag, input logic dir, input logic sgn, input logic [31:0] s,
                      input logic [31:0] exp_res, input logic [4:0] exp_flags, input int exp_lat);
      int lat;
      @(negedge clk);
      check({tag, ".ready"}, {31'd0, cvt_ready}, 32'd1);
      cvt_valid  = 1'b1;
      cvt_dir    = dir;
      cvt_signed = sgn;
      src        = s;
      @(posedge clk);
      #1;
      cvt_valid = 1'b0;
      src       = 32'hDEAD_BEEF;
      lat = 1;
      while (!res_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".valid"}, {31'd0, res_valid}, 32'd1);
      check({tag, ".res"}, res, exp_res);
      check({tag, ".flags"}, {27'd0, fflags}, {27'd0, exp_flags});
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check({tag, ".clr"}, {res_valid, 26'd0, fflags}, 32'd0);
      check({tag, ".res0"}, res, 32'd0);
   endtask

   initial begin
      logic [31:0] held_res;
      logic [4:0]  held_flags;
      int          bad;

      #2;
      check("rst.ready", {31'd0, cvt_ready}, 32'd1);
      check("rst.valid", {31'd0, res_valid}, 32'd0);
      check("rst.res", res, 32'd0);
      check("rst.flags", {27'd0, fflags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // INT -> FP
      run("i2f_1",     1'b0, 1'b1, 32'h0000_0001, 32'h3F80_0000, 5'h00, 34);
      run("i2f_max",   1'b0, 1'b1, 32'h7FFF_FFFF, 32'h4F00_0000, 5'h01, 4);
      run("i2f_zero",  1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'h00, 1);
      run("i2f_min",   1'b0, 1'b1, 32'h8000_0000, 32'hCF00_0000, 5'h00, 3);
      run("i2f_m1",    1'b0, 1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 5'h00, 34);
      run("i2f_umax",  1'b0, 1'b0, 32'hFFFF_FFFF, 32'h4F80_0000, 5'h01, 3);
      run("i2f_3",     1'b0, 1'b0, 32'h0000_0003, 32'h4040_0000, 5'h00, 33);
      run("i2f_tie",   1'b0, 1'b1, 32'h0100_0001, 32'h4B80_0000, 5'h01, 10);
      run("i2f_tieup", 1'b0, 1'b1, 32'h0100_0003, 32'h4B80_0002, 5'h01, 10);

      // FP -> INT
      run("f2i_m375",  1'b1, 1'b1, 32'hC070_0000, 32'hFFFF_FFFD, 5'h01, 32);
      run("f2i_min",   1'b1, 1'b1, 32'hCF00_0000, 32'h8000_0000, 5'h00, 2);
      run("f2i_nan",   1'b1, 1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 5'h10, 1);
      run("f2i_unan",  1'b1, 1'b0, 32'h7FC0_0000, 32'hFFFF_FFFF, 5'h10, 1);
      run("f2u_m1",    1'b1, 1'b0, 32'hBF80_0000, 32'h0000_0000, 5'h10, 1);
      run("f2u_mhalf", 1'b1, 1'b0, 32'hBF00_0000, 32'h0000_0000, 5'h01, 1);
      run("f2i_half",  1'b1, 1'b1, 32'h3F00_0000, 32'h0000_0000, 5'h01, 1);
      run("f2i_zero",  1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'h00, 1);
      run("f2i_one",   1'b1, 1'b1, 32'h3F80_0000, 32'h0000_0001, 5'h00, 33);
      run("f2i_1p5",   1'b1, 1'b1, 32'h3FC0_0000, 32'h0000_0001, 5'h01, 33);
      run("f2i_inf",   1'b1, 1'b1, 32'h7F80_0000, 32'h7FFF_FFFF, 5'h10, 1);
      run("f2i_minf",  1'b1, 1'b1, 32'hFF80_0000, 32'h8000_0000, 5'h10, 1);
      run("f2i_2p31",  1'b1, 1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 5'h10, 1);
      run("f2u_2p31",  1'b1, 1'b0, 32'h4F00_0000, 32'h8000_0000, 5'h00, 2);
      run("f2u_2p32",  1'b1, 1'b0, 32'h4F80_0000, 32'hFFFF_FFFF, 5'h10, 1);

      // Backpressure: hold the result for 10 cycles and poke cvt_valid meanwhile.
      @(negedge clk);
      cvt_valid = 1'b1; cvt_dir = 1'b0; cvt_signed = 1'b0; src = 32'h0000_0003;
      @(posedge clk);
      #1;
      cvt_valid = 1'b0;
      for (int i = 0; i < 60 && !res_valid; i++) begin
         @(posedge clk);
         #1;
      end
      check("bp.valid", {31'd0, res_valid}, 32'd1);
      held_res   = 32'h4040_0000;
      held_flags = 5'h00;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cvt_valid = (i == 4);
         src       = 32'h0000_0000;
         if (!res_valid || res !== held_res || fflags !== held_flags || cvt_ready) bad++;
      end
      cvt_valid = 1'b0;
      check("bp.hold", 32'(bad), 32'd0);
      check("bp.res", res, 32'h4040_0000);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (res_valid || !cvt_ready) bad++;
      end
      check("bp.noacc", 32'(bad), 32'd0);

      // Reset while normalising src=1; the aborted result must never appear.
      @(negedge clk);
      cvt_valid = 1'b1; cvt_dir = 1'b0; cvt_signed = 1'b1; src = 32'h0000_0001;
      @(posedge clk);
      #1;
      cvt_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("ar.ready", {31'd0, cvt_ready}, 32'd1);
      check("ar.out", {res_valid, 26'd0, fflags}, 32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      run("ar_zero", 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'h00, 1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (res_valid) bad++;
      end
      check("ar.ghost", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
